// File: rtl/mul2_frac_pkg.sv
// -----------------------------------------------------------------------------
// mul2_frac_pkg
// Shared constants and the controller state type for the sequential
// fixed-point multiplier mul2_frac (o = floor(a * f / 2^F_W)).
// No ports.
// -----------------------------------------------------------------------------
package mul2_frac_pkg;

    localparam int MUL2_A_W  = 22;             // integer operand / result width
    localparam int MUL2_F_W  = 32;             // fraction width, 0.F_W format
    localparam int MUL2_ITER = MUL2_F_W / 2;   // radix-4 steps per operation

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul2_frac_pkg

// File: rtl/mul2_frac_if.sv
// -----------------------------------------------------------------------------
// mul2_frac_if
// Operand / result handshake bundle for mul2_frac.
//   in_valid, in_ready : operand handshake (producer -> multiplier)
//   a [A_W]            : unsigned integer multiplicand
//   f [F_W]            : unsigned 0.F_W fractional multiplier
//   out_valid, out_ready : result handshake (multiplier -> consumer)
//   o [A_W]            : result
// Modports: master = the side that supplies operands and takes results,
//           slave  = the multiplier.
// -----------------------------------------------------------------------------
interface mul2_frac_if
    import mul2_frac_pkg::*;
#(
    parameter int A_W = MUL2_A_W,
    parameter int F_W = MUL2_F_W
);

    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [F_W-1:0] f;
    logic           out_valid;
    logic           out_ready;
    logic [A_W-1:0] o;

    modport master (
        output in_valid, a, f, out_ready,
        input  in_ready, out_valid, o
    );

    modport slave (
        input  in_valid, a, f, out_ready,
        output in_ready, out_valid, o
    );

endinterface : mul2_frac_if

// File: rtl/mul2_frac_pe.sv
// -----------------------------------------------------------------------------
// mul2_frac_pe
// Combinational radix-4 shift-add step: acc_next = (acc << 2) + a * digit.
// The digit multiple is formed from a, 2a or 3a = a + 2a, so no multiplier
// is needed.
// Ports:
//   acc      [ACC_W] in  : running accumulator
//   a        [A_W]   in  : integer multiplicand
//   digit    [2]     in  : current two fraction bits (MSB first)
//   acc_next [ACC_W] out : updated accumulator
// -----------------------------------------------------------------------------
module mul2_frac_pe #(
    parameter int A_W   = 22,
    parameter int ACC_W = 56
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [A_W-1:0]   a,
    input  logic [1:0]       digit,
    output logic [ACC_W-1:0] acc_next
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] term;

    assign a_ext = ACC_W'(a);

    always_comb begin
        // NOTE: default assignment first so every path drives term; without
        // it a missed case item would infer a latch.
        term = '0;
        case (digit)
            2'd1:    term = a_ext;
            2'd2:    term = a_ext << 1;
            2'd3:    term = a_ext + (a_ext << 1);
            default: term = '0;
        endcase
    end

    assign acc_next = (acc << 2) + term;

endmodule : mul2_frac_pe

// File: rtl/mul2_frac.sv
// -----------------------------------------------------------------------------
// mul2_frac
// Sequential fixed-point multiplier: o = floor(a * f / 2^F_W), with a an
// unsigned integer and f an unsigned 0.F_W fraction. Re-scales block values
// by normalisation factors from the companion 0.32-quotient divider.
// Two fraction bits are consumed per cycle, MSB first (F_W/2 steps). One
// operation is in flight at a time; a result is presented 17 edges after the
// operands are accepted (for F_W = 32) and held until taken.
//
// Optional feature: define MUL2_FRAC_ROUND_EN for round-half-up,
// o = floor((a * f + 2^(F_W-1)) / 2^F_W). Default build truncates.
//
// Ports:
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus      : mul2_frac_if.slave (in_valid/in_ready/a/f,
//              out_valid/out_ready/o)
// Parameters: A_W operand/result width, F_W fraction width (even),
//             CNT_W step counter width (F_W/2 <= 2^CNT_W).
// -----------------------------------------------------------------------------
module mul2_frac
    import mul2_frac_pkg::*;
#(
    parameter int A_W   = MUL2_A_W,
    parameter int F_W   = MUL2_F_W,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mul2_frac_if.slave  bus
);

    // Two bits of headroom so the pre-shift accumulator never loses bits;
    // a*f < 2^(A_W+F_W) bounds every partial sum.
    localparam int               ACC_W    = A_W + F_W + 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(F_W / 2 - 1);

`ifdef MUL2_FRAC_ROUND_EN
    // Half an output LSB; only the final step's sum is registered into o,
    // so the half is effectively added in the last BUSY cycle.
    localparam logic [ACC_W-1:0] ROUND_ADD = ACC_W'(1) << (F_W - 1);
`else
    localparam logic [ACC_W-1:0] ROUND_ADD = '0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [A_W-1:0]   a_q;
    logic [F_W-1:0]   f_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_step;
    logic [ACC_W-1:0] acc_fin;
    logic [A_W-1:0]   o_q;
    logic             accept;
    logic             last_step;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (state == BUSY) && (cnt == '0);

    mul2_frac_pe #(
        .A_W   (A_W),
        .ACC_W (ACC_W)
    ) u_pe (
        .acc      (acc),
        .a        (a_q),
        .digit    (f_q[F_W-1 -: 2]),
        .acc_next (acc_step)
    );

    // The rounded sum never exceeds a, so the slice above F_W fits in A_W.
    assign acc_fin = acc_step + ROUND_ADD;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples the pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = BUSY;
            BUSY:    if (last_step)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    assign bus.o = o_q;

    // ---------------- datapath ----------------
    // Operands are captured only on acceptance, so changes on a/f/in_valid
    // during BUSY/DONE have no effect. o_q is only written on the last step,
    // which keeps it stable through DONE and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            f_q <= '0;
            acc <= '0;
            cnt <= '0;
            o_q <= '0;
        end else if (accept) begin
            a_q <= bus.a;
            f_q <= bus.f;
            acc <= '0;
            cnt <= CNT_INIT;
        end else if (state == BUSY) begin
            acc <= acc_step;
            f_q <= f_q << 2;
            if (cnt == '0) begin
                o_q <= A_W'(acc_fin >> F_W);
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule : mul2_frac

// File: tb/tb_mul2_frac.sv
// -----------------------------------------------------------------------------
// tb_mul2_frac
// Self-checking bench for mul2_frac. A transaction-level model predicts each
// result as floor((a*f [+ 2^(F_W-1)]) / 2^F_W) with 64-bit arithmetic, and
// tracks when a result must be pending; a compare process checks in_ready,
// out_valid and o against it on every falling edge. Directed operations carry
// hand-computed literal results. Build with MUL2_FRAC_ROUND_EN to check the
// rounding variant.
// -----------------------------------------------------------------------------
module tb_mul2_frac;
    import mul2_frac_pkg::*;

    localparam int A_W = MUL2_A_W;
    localparam int F_W = MUL2_F_W;
`ifdef MUL2_FRAC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam int LATENCY = 17;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mul2_frac_if #(.A_W(A_W), .F_W(F_W)) bus_if ();

    mul2_frac #(
        .A_W   (A_W),
        .F_W   (F_W),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint unsigned model(input longint unsigned a,
                                              input longint unsigned f);
        longint unsigned p;
        p = a * f;
        if (ROUND) p = p + (longint'(1) << (F_W - 1));
        return p >> F_W;
    endfunction

    // ---------------- reference model state ----------------
    longint unsigned exp_q[$];
    bit              outstanding = 1'b0;
    int              edges       = 0;   // edges since acceptance, acceptance edge = 1

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 1'b0;
            edges       = 0;
        end else if (outstanding) begin
            if (bus_if.out_valid && bus_if.out_ready) begin
                void'(exp_q.pop_front());
                outstanding = 1'b0;
            end else if (edges < 1000) begin
                edges++;
            end
        end else if (bus_if.in_valid && bus_if.in_ready) begin
            exp_q.push_back(model(longint'(bus_if.a), longint'(bus_if.f)));
            outstanding = 1'b1;
            edges       = 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", longint'(bus_if.in_ready), longint'(!outstanding));
            check("out_valid", longint'(bus_if.out_valid),
                  longint'(outstanding && edges >= LATENCY));
            if (bus_if.out_valid && exp_q.size() != 0)
                check("o_model", longint'(bus_if.o), exp_q[0]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic start_op(input logic [A_W-1:0] a, input logic [F_W-1:0] f);
        bus_if.a        = a;
        bus_if.f        = f;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.a        = ~a;        // operand changes while busy are ignored
        bus_if.f        = ~f;
    endtask

    task automatic wait_valid(input string name);
        int n = 1;
        while (!bus_if.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, longint'(n), longint'(LATENCY));
    endtask

    task automatic finish_op(input string name, input longint unsigned exp);
        check({name, "_o"}, longint'(bus_if.o), exp);
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        check({name, "_in_ready_after"}, longint'(bus_if.in_ready), 1);
    endtask

    task automatic run_op(input string name, input logic [A_W-1:0] a,
                          input logic [F_W-1:0] f, input longint unsigned exp);
        start_op(a, f);
        wait_valid(name);
        finish_op(name, exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    bit stop_ready;

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.f         = '0;
        bus_if.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(bus_if.in_ready), 1);
        check("rst_out_valid", longint'(bus_if.out_valid), 0);
        check("rst_o", longint'(bus_if.o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed expectations.
        run_op("half", 22'd1000, 32'h8000_0000, 500);
        run_op("max", 22'd4194303, 32'hFFFF_FFFF, ROUND ? 4194303 : 4194302);
        run_op("third", 22'd3, 32'h5555_5555, ROUND ? 1 : 0);
        run_op("zero_zero", 22'd0, 32'h0, 0);
        run_op("f_zero", 22'd123, 32'h0, 0);

        // Backpressure: 777 * 0x12345678 / 2^32 = 55.25 -> 55 either way.
        start_op(22'd777, 32'h1234_5678);
        wait_valid("bp");
        bus_if.a        = 22'd5;
        bus_if.f        = 32'hFFFF_FFFF;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_o_stable", longint'(bus_if.o), 55);
            check("bp_in_ready", longint'(bus_if.in_ready), 0);
            check("bp_out_valid", longint'(bus_if.out_valid), 1);
        end
        bus_if.in_valid = 1'b0;
        finish_op("bp", 55);

        // Reset eight edges into BUSY.
        start_op(22'd999, 32'hABCD_EF01);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", longint'(bus_if.out_valid), 0);
        check("mid_rst_in_ready", longint'(bus_if.in_ready), 1);
        @(posedge clk); #1;
        check("mid_rst_out_valid_held", longint'(bus_if.out_valid), 0);
        check("mid_rst_in_ready_held", longint'(bus_if.in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 22'd10, 32'h4000_0000, ROUND ? 3 : 2);

        // Randomised traffic against the model.
        stop_ready = 1'b0;
        fork
            begin : driver
                bit rdy;
                int guard;
                for (int n = 0; n < 2000; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    case ($urandom_range(0, 7))
                        0:       bus_if.a = '0;
                        1:       bus_if.a = '1;
                        default: bus_if.a = A_W'($urandom);
                    endcase
                    case ($urandom_range(0, 7))
                        0:       bus_if.f = '0;
                        1:       bus_if.f = '1;
                        default: bus_if.f = F_W'($urandom);
                    endcase
                    bus_if.in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        rdy = bus_if.in_ready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!rdy && guard < 200);
                    if (!rdy) check("accept_timeout", longint'(rdy), 1);
                    bus_if.in_valid = 1'b0;
                    bus_if.a        = A_W'($urandom);
                    bus_if.f        = F_W'($urandom);
                end
                guard = 0;
                while (outstanding && guard < 200) begin
                    @(posedge clk); #1;
                    guard++;
                end
                check("drain", longint'(outstanding), 0);
                stop_ready = 1'b1;
            end
            begin : ready_gen
                while (!stop_ready) begin
                    @(posedge clk); #1;
                    bus_if.out_ready = ($urandom_range(0, 2) != 0);
                end
                bus_if.out_ready = 1'b0;
            end
        join

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mul2_frac
